ord_arbiter: RTL and testbench
==============================

ORD_ARBITER -- requirements
Module: ord_arbiter

Interface
- REQ-001: Parameter N_REQ, default 4: number of requesters (≥2); requester index is the transaction ID.
- REQ-002: Parameter ID_W, default $clog2(N_REQ): ID width, matching the reorder buffer's FIX_ID=1 ID width.
- REQ-003: Parameter LEN_W, default 16: burst length width (encoded length-1).
- REQ-004: Parameter MAX_OUTS, default 4: maximum outstanding transactions per ID (≥1).
- REQ-005: clk  in  1  single clock; all logic is on its rising edge.
- REQ-006: rst  in  1  synchronous, active-high reset.
- REQ-007: req_len  in  N_REQ*LEN_W  per-requester length; requester i uses bits [(i+1)*LEN_W-1 -: LEN_W].
- REQ-008: req_vld  in  N_REQ  per-requester request valid.
- REQ-009: req_rdy  out  N_REQ  per-requester accept; at most one bit high per cycle.
- REQ-010: cmd_id/cmd_len/cmd_vld  out  ID_W/LEN_W/1  command to the downstream target; cmd_rdy  in  1.
- REQ-011: ord_id/ord_len/ord_vld  out  ID_W/LEN_W/1  order entry to the reorder buffer; ord_rdy  in  1.
- REQ-012: cpl_id  in  ID_W, cpl_vld  in  1  single-cycle pulse per completed transaction (last beat forwarded).
- REQ-013: busy  out  1  high while the FSM is in ISSUE.
- REQ-014: cpl_err  out  1  sticky flag: completion received for an ID with zero outstanding.

Function
- REQ-015: The FSM SHALL have two states, IDLE and ISSUE; reset state is IDLE.
- REQ-016: Requester i is eligible iff req_vld[i]=1 and outstanding[i] < MAX_OUTS.
- REQ-017: In IDLE with ≥1 eligible requester, the FSM SHALL select one winner, drive req_rdy[winner]=1 in that cycle, latch the ID and length, and go to ISSUE.
- REQ-018: req_rdy SHALL be 0 in ISSUE and for all non-winners.
- REQ-019: cmd_vld and ord_vld SHALL both assert in the cycle after acceptance; cmd_id=ord_id=winner index; cmd_len=ord_len=latched req_len.
- REQ-020: cmd_vld SHALL drop after its handshake, and ord_vld SHALL drop after its handshake, independently; each channel's handshake is recorded in a done flag.
- REQ-021: The FSM SHALL return to IDLE in the cycle after both handshakes have occurred, whether they happened in the same cycle or in different cycles.
- REQ-022: cmd_* and ord_* SHALL stay stable while their vld is high and rdy is low.
- REQ-023: Minimum issue period is 2 cycles per transaction.
- REQ-024: outstanding[id] is a $clog2(MAX_OUTS+1)-bit counter per ID: +1 on acceptance, -1 on cpl_vld for that ID.
- REQ-025: When increment and decrement hit the same ID in the same cycle, the counter SHALL remain unchanged.
- REQ-026: cpl_vld for an ID whose counter is 0 SHALL leave the counter at 0 (no wrap) and set cpl_err.
- REQ-027: cpl_id ≥ N_REQ with cpl_vld=1 SHALL be ignored and SHALL set cpl_err.

Reset
- REQ-028: On rst=1 at a clock edge, the block SHALL drive req_rdy=0, cmd_vld=0, ord_vld=0, cmd_id/cmd_len/ord_id/ord_len=0, busy=0 and cpl_err=0.
- REQ-029: On the same reset, all outstanding counters and done flags SHALL clear, and the RR pointer SHALL load N_REQ-1.
- REQ-030: A reset asserted during ISSUE SHALL discard the pending transaction without completing any handshake.

Configuration
- REQ-031: With `ORD_ARBITER_RR_EN defined, the winner SHALL be the first eligible index searching from pointer+1 with wrap-around; the pointer updates to the winner only on acceptance.
- REQ-032: Without `ORD_ARBITER_RR_EN, the winner SHALL be the lowest eligible index (fixed priority), and no pointer register SHALL exist.

Structure
- REQ-033: Package ord_arbiter_pkg SHALL hold the FSM state encoding (IDLE=0, ISSUE=1) and the counter-width constant function.
- REQ-034: One combinational sub-module, ord_arbiter_sel, SHALL compute the one-hot grant from the eligible vector and pointer; one-hot to index conversion SHALL reuse the existing onehot_encoder.

Verification
- REQ-035: Scenario: req_vld=4'b0100, len=7, cmd_rdy=ord_rdy=1 -> req_rdy[2] high at T; cmd/ord_vld high at T+1 with id=2, len=7; back in IDLE at T+2.
- REQ-036: Scenario: cmd_rdy=1, ord_rdy held 0 for 3 cycles -> cmd_vld lasts 1 cycle, ord_vld lasts 4 cycles, and no new grant occurs until the ord handshake.
- REQ-037: Scenario: RR enabled, req_vld=4'b1111 held -> grant order 0,1,2,3,0; RR disabled -> grants to 0 only.
- REQ-038: Scenario: MAX_OUTS=4, requester 1 valid with no completions -> 4 grants, then req_rdy[1] stays 0; one cpl_vld with cpl_id=1 -> one more grant.
- REQ-039: Scenario: cpl_vld for an ID with counter 0 -> counter stays 0 and cpl_err=1 until rst; simultaneous accept and cpl on the same ID -> count unchanged.
- REQ-040: Scenario: rst pulsed during ISSUE -> next cycle all valids are 0, counters are 0, and busy is 0.

Source files
------------

// File: rtl/ord_arbiter_pkg.sv
// Shared definitions for ord_arbiter: FSM state encoding and the
// per-ID outstanding-counter width helper.
package ord_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  // Counter must hold 0..max_outs inclusive.
  function automatic int unsigned cnt_width(input int unsigned max_outs);
    return $clog2(max_outs + 1);
  endfunction

endpackage

// File: rtl/ord_arbiter_if.sv
// Request / command / order / completion bundle for ord_arbiter.
// master = arbiter side, slave = requesters, target and reorder buffer.
interface ord_arbiter_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = $clog2(N_REQ),
  parameter int unsigned LEN_W = 16
);
  logic [N_REQ*LEN_W-1:0] req_len;
  logic [N_REQ-1:0]       req_vld;
  logic [N_REQ-1:0]       req_rdy;
  logic [ID_W-1:0]        cmd_id;
  logic [LEN_W-1:0]       cmd_len;
  logic                   cmd_vld;
  logic                   cmd_rdy;
  logic [ID_W-1:0]        ord_id;
  logic [LEN_W-1:0]       ord_len;
  logic                   ord_vld;
  logic                   ord_rdy;
  logic [ID_W-1:0]        cpl_id;
  logic                   cpl_vld;
  logic                   busy;
  logic                   cpl_err;

  modport master (
    input  req_len, req_vld, cmd_rdy, ord_rdy, cpl_id, cpl_vld,
    output req_rdy, cmd_id, cmd_len, cmd_vld, ord_id, ord_len, ord_vld,
           busy, cpl_err
  );

  modport slave (
    output req_len, req_vld, cmd_rdy, ord_rdy, cpl_id, cpl_vld,
    input  req_rdy, cmd_id, cmd_len, cmd_vld, ord_id, ord_len, ord_vld,
           busy, cpl_err
  );
endinterface

// File: rtl/onehot_encoder.sv
// One-hot to binary index encoder (OR of the indices of all set bits).
module onehot_encoder #(
  parameter int unsigned N = 4,
  parameter int unsigned W = $clog2(N)
) (
  input  logic [N-1:0] i_onehot,
  output logic [W-1:0] o_idx
);
  logic w_bit;

  always_comb begin
    o_idx = '0;
    w_bit = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      w_bit = |(i_onehot & (N'(1) << k));
      if (w_bit) o_idx = o_idx | W'(k);
    end
  end
endmodule

// File: rtl/ord_arbiter_sel.sv
// Combinational grant selection. `ORD_ARBITER_RR_EN: round-robin from
// pointer+1 with wrap; otherwise fixed priority, lowest index wins.
module ord_arbiter_sel #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_elig,
`ifdef ORD_ARBITER_RR_EN
  input  logic [ID_W-1:0]  i_ptr,
`endif
  output logic [N_REQ-1:0] o_grant
);
`ifdef ORD_ARBITER_RR_EN
  logic [31:0]          w_sh;
  logic [N_REQ-1:0]     w_rot;
  logic [N_REQ-1:0]     w_lsb;
  logic [2*N_REQ-1:0]   w_back;

  // Rotate so pointer+1 lands at bit 0, pick lowest set bit, rotate back.
  always_comb begin
    w_sh    = 32'(i_ptr) + 32'd1;
    w_rot   = N_REQ'({i_elig, i_elig} >> w_sh);
    w_lsb   = w_rot & (~w_rot + N_REQ'(1));
    w_back  = {{N_REQ{1'b0}}, w_lsb} << w_sh;
    o_grant = w_back[N_REQ-1:0] | w_back[2*N_REQ-1:N_REQ];
  end
`else
  always_comb begin
    o_grant = i_elig & (~i_elig + N_REQ'(1));
  end
`endif
endmodule

// File: rtl/ord_arbiter.sv
// Ordered-issue arbiter: grants one requester, issues the command and the
// reorder-buffer entry, tracks outstanding per ID. `ORD_ARBITER_RR_EN = RR.
module ord_arbiter
  import ord_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned ID_W     = $clog2(N_REQ),
  parameter int unsigned LEN_W    = 16,
  parameter int unsigned MAX_OUTS = 4
) (
  input logic          clk,
  input logic          rst,
  ord_arbiter_if.master bus
);
  localparam int unsigned CNT_W = cnt_width(MAX_OUTS);

  state_t           r_state, w_next;
  logic [ID_W-1:0]  r_id;
  logic [LEN_W-1:0] r_len;
  logic             r_cmd_done, r_ord_done, r_err;
  logic [N_REQ-1:0] w_elig, w_grant, w_req_rdy, w_cpl_zero;
  logic [ID_W-1:0]  w_win;
  logic             w_accept, w_cmd_vld, w_ord_vld, w_cmd_hs, w_ord_hs;
  logic             w_cpl_oob;

  for (genvar g = 0; g < N_REQ; g++) begin : g_cnt
    logic [CNT_W-1:0] r_cnt;
    logic             w_hit, w_inc, w_dec;
    assign w_hit         = bus.cpl_vld && (bus.cpl_id == ID_W'(g));
    assign w_inc         = w_accept && w_grant[g];
    assign w_dec         = w_hit && (r_cnt != '0);
    assign w_cpl_zero[g] = w_hit && (r_cnt == '0);
    assign w_elig[g]     = bus.req_vld[g] && (r_cnt < CNT_W'(MAX_OUTS));
    always_ff @(posedge clk) begin
      if (rst)                  r_cnt <= '0;
      else if (w_inc && !w_dec) r_cnt <= r_cnt + CNT_W'(1);
      else if (w_dec && !w_inc) r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign w_cpl_oob = bus.cpl_vld && (32'(bus.cpl_id) >= N_REQ);

`ifdef ORD_ARBITER_RR_EN
  logic [ID_W-1:0] r_ptr;
  always_ff @(posedge clk) begin
    if (rst)           r_ptr <= ID_W'(N_REQ - 1);
    else if (w_accept) r_ptr <= w_win;
  end
  ord_arbiter_sel #(.N_REQ(N_REQ), .ID_W(ID_W)) u_sel (
    .i_elig(w_elig), .i_ptr(r_ptr), .o_grant(w_grant)
  );
`else
  ord_arbiter_sel #(.N_REQ(N_REQ), .ID_W(ID_W)) u_sel (
    .i_elig(w_elig), .o_grant(w_grant)
  );
`endif

  onehot_encoder #(.N(N_REQ), .W(ID_W)) u_enc (
    .i_onehot(w_grant), .o_idx(w_win)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // ISSUE ends once each channel has handshaken, in any cycle order.
  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_req_rdy = '0;
    w_cmd_vld = 1'b0;
    w_ord_vld = 1'b0;
    w_cmd_hs  = 1'b0;
    w_ord_hs  = 1'b0;
    case (r_state)
      IDLE: begin
        if (!rst && (|w_elig)) begin
          w_accept  = 1'b1;
          w_req_rdy = w_grant;
          w_next    = ISSUE;
        end
      end
      ISSUE: begin
        w_cmd_vld = !r_cmd_done;
        w_ord_vld = !r_ord_done;
        w_cmd_hs  = w_cmd_vld && bus.cmd_rdy;
        w_ord_hs  = w_ord_vld && bus.ord_rdy;
        if ((r_cmd_done || w_cmd_hs) && (r_ord_done || w_ord_hs)) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_id       <= '0;
      r_len      <= '0;
      r_cmd_done <= 1'b0;
      r_ord_done <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_id       <= w_win;
        r_len      <= bus.req_len[w_win*LEN_W +: LEN_W];
        r_cmd_done <= 1'b0;
        r_ord_done <= 1'b0;
      end else begin
        if (w_cmd_hs) r_cmd_done <= 1'b1;
        if (w_ord_hs) r_ord_done <= 1'b1;
      end
      r_err <= r_err || w_cpl_oob || (|w_cpl_zero);
    end
  end

  assign bus.req_rdy = w_req_rdy;
  assign bus.cmd_vld = w_cmd_vld;
  assign bus.ord_vld = w_ord_vld;
  assign bus.cmd_id  = r_id;
  assign bus.cmd_len = r_len;
  assign bus.ord_id  = r_id;
  assign bus.ord_len = r_len;
  assign bus.busy    = (r_state == ISSUE);
  assign bus.cpl_err = r_err;
endmodule

// File: tb/tb_ord_arbiter.sv
// Randomized scoreboard bench for ord_arbiter against a transaction-level model.
module tb_ord_arbiter;
  localparam int unsigned N_REQ    = 4;
  localparam int unsigned ID_W     = 2;
  localparam int unsigned LEN_W    = 16;
  localparam int unsigned MAX_OUTS = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ord_arbiter_if #(.N_REQ(N_REQ), .ID_W(ID_W), .LEN_W(LEN_W)) bus ();

  ord_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W), .LEN_W(LEN_W), .MAX_OUTS(MAX_OUTS)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct {
    int               id;
    logic [LEN_W-1:0] len;
  } xact_t;

  xact_t cmd_q[$];
  xact_t ord_q[$];
  int total = 0;
  int bad   = 0;

  int               m_cnt [N_REQ];
  int               m_ptr;
  bit               m_busy, m_cmd_pend, m_ord_pend, m_err;
  int               m_id;
  logic [LEN_W-1:0] m_len;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit bitat(input logic [N_REQ-1:0] v, input int i);
    logic [N_REQ-1:0] s;
    s = v >> i;
    return s[0];
  endfunction

  function automatic logic [N_REQ*LEN_W-1:0] rand_lens();
    return {$urandom(), $urandom()};
  endfunction

  task automatic model_reset();
    foreach (m_cnt[i]) m_cnt[i] = 0;
    m_ptr = N_REQ - 1;
    m_busy = 0; m_cmd_pend = 0; m_ord_pend = 0; m_err = 0;
    m_id = 0; m_len = '0;
    cmd_q.delete();
    ord_q.delete();
  endtask

  // One clock of stimulus; outputs checked at the falling edge, model advanced after.
  task automatic cycle(input logic r, input logic [N_REQ-1:0] vld_in,
                       input logic [N_REQ*LEN_W-1:0] lens, input logic crdy_in,
                       input logic ordy_in, input logic cv_in, input logic [ID_W-1:0] cid);
    int win, idx;
    logic [N_REQ-1:0] vld, exp_rdy;
    logic crdy, ordy, cv;
    xact_t x;
    vld  = r ? '0 : vld_in;
    crdy = r ? 1'b0 : crdy_in;
    ordy = r ? 1'b0 : ordy_in;
    cv   = r ? 1'b0 : cv_in;
    @(posedge clk); #1;
    rst = r;
    bus.req_vld = vld; bus.req_len = lens;
    bus.cmd_rdy = crdy; bus.ord_rdy = ordy;
    bus.cpl_vld = cv; bus.cpl_id = cid;
    win = -1;
    if (!m_busy && !r) begin
`ifdef ORD_ARBITER_RR_EN
      for (int k = 1; k <= N_REQ; k++) begin
        idx = (m_ptr + k) % N_REQ;
        if (win < 0 && bitat(vld, idx) && m_cnt[idx] < MAX_OUTS) win = idx;
      end
`else
      for (int k = 0; k < N_REQ; k++)
        if (win < 0 && bitat(vld, k) && m_cnt[k] < MAX_OUTS) win = k;
`endif
    end
    exp_rdy = (win >= 0) ? (N_REQ'(1) << win) : '0;
    @(negedge clk);
    chk("req_rdy", bus.req_rdy, exp_rdy);
    chk("busy", bus.busy, m_busy);
    chk("cmd_vld", bus.cmd_vld, m_busy && m_cmd_pend);
    chk("ord_vld", bus.ord_vld, m_busy && m_ord_pend);
    chk("cpl_err", bus.cpl_err, m_err);
    if (m_busy && m_cmd_pend) begin
      chk("cmd_id", bus.cmd_id, m_id);
      chk("cmd_len", bus.cmd_len, m_len);
    end
    if (m_busy && m_ord_pend) begin
      chk("ord_id", bus.ord_id, m_id);
      chk("ord_len", bus.ord_len, m_len);
    end
    if (r) begin
      model_reset();
    end else begin
      if (m_busy) begin
        if (m_cmd_pend && crdy) m_cmd_pend = 0;
        if (m_ord_pend && ordy) m_ord_pend = 0;
        if (!m_cmd_pend && !m_ord_pend) m_busy = 0;
      end
      if (cv) begin
        if (int'(cid) >= N_REQ || m_cnt[cid] == 0) m_err = 1;
        else m_cnt[cid]--;
      end
      if (win >= 0) begin
        m_cnt[win]++;
        m_busy = 1; m_cmd_pend = 1; m_ord_pend = 1;
        m_id = win; m_ptr = win;
        m_len = lens[win*LEN_W +: LEN_W];
        x.id = win; x.len = m_len;
        cmd_q.push_back(x);
        ord_q.push_back(x);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b1, 1'b1, 1'b0, '0);
  endtask

  task automatic do_reset();
    cycle(1'b1, '0, '0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  // Scoreboard: every handshake must match the oldest predicted transaction.
  initial begin
    xact_t e;
    forever begin
      @(negedge clk);
      if (bus.cmd_vld && bus.cmd_rdy) begin
        if (cmd_q.size() == 0) begin
          total++; bad++;
          $display("FAIL sb_cmd: unexpected cmd id=%0d len=%0d expected none", bus.cmd_id, bus.cmd_len);
        end else begin
          e = cmd_q.pop_front();
          chk("sb_cmd_id", bus.cmd_id, e.id);
          chk("sb_cmd_len", bus.cmd_len, e.len);
        end
      end
      if (bus.ord_vld && bus.ord_rdy) begin
        if (ord_q.size() == 0) begin
          total++; bad++;
          $display("FAIL sb_ord: unexpected ord id=%0d len=%0d expected none", bus.ord_id, bus.ord_len);
        end else begin
          e = ord_q.pop_front();
          chk("sb_ord_id", bus.ord_id, e.id);
          chk("sb_ord_len", bus.ord_len, e.len);
        end
      end
    end
  end

  initial begin
    logic [N_REQ*LEN_W-1:0] lens;
    logic [ID_W-1:0] cid;
    logic r;
    rst = 1'b1;
    bus.req_vld = '0; bus.req_len = '0; bus.cmd_rdy = 1'b0; bus.ord_rdy = 1'b0;
    bus.cpl_vld = 1'b0; bus.cpl_id = '0;
    repeat (2) @(posedge clk);
    model_reset();
    idle(1);
    chk("rst_cmd_id", bus.cmd_id, 0);
    chk("rst_cmd_len", bus.cmd_len, 0);
    chk("rst_ord_id", bus.ord_id, 0);
    chk("rst_ord_len", bus.ord_len, 0);

    // Single grant to requester 2 with len 7, both sinks ready.
    lens = '0; lens[2*LEN_W +: LEN_W] = 16'd7;
    for (int i = 0; i < 3; i++) cycle(1'b0, 4'b0100, lens, 1'b1, 1'b1, 1'b0, '0);
    idle(2);

    // Order channel stalled three cycles while all requesters stay valid.
    lens = rand_lens();
    cycle(1'b0, 4'b1111, lens, 1'b1, 1'b1, 1'b0, '0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 4'b1111, lens, 1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 4'b1111, lens, 1'b1, 1'b1, 1'b0, '0);

    // All valid, each issued transaction completed while it is issued.
    do_reset();
    for (int i = 0; i < 10; i++)
      cycle(1'b0, 4'b1111, rand_lens(), 1'b1, 1'b1, m_busy, ID_W'(m_id));

    // Outstanding limit on requester 1, then one completion frees a slot.
    do_reset();
    for (int i = 0; i < 12; i++) cycle(1'b0, 4'b0010, rand_lens(), 1'b1, 1'b1, 1'b0, '0);
    cycle(1'b0, 4'b0010, rand_lens(), 1'b1, 1'b1, 1'b1, 2'd1);
    for (int i = 0; i < 5; i++) cycle(1'b0, 4'b0010, rand_lens(), 1'b1, 1'b1, 1'b0, '0);

    // Completion with zero outstanding, then accept and completion on one ID together.
    do_reset();
    cycle(1'b0, '0, '0, 1'b1, 1'b1, 1'b1, 2'd3);
    cycle(1'b0, 4'b0001, rand_lens(), 1'b1, 1'b1, 1'b0, '0);
    cycle(1'b0, '0, '0, 1'b1, 1'b1, 1'b0, '0);
    cycle(1'b0, 4'b0001, rand_lens(), 1'b1, 1'b1, 1'b1, 2'd0);
    for (int i = 0; i < 9; i++) cycle(1'b0, 4'b0001, rand_lens(), 1'b1, 1'b1, 1'b0, '0);

    // Reset while a transaction is being issued.
    do_reset();
    cycle(1'b0, 4'b1000, rand_lens(), 1'b0, 1'b0, 1'b0, '0);
    cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0);
    do_reset();
    idle(1);
    chk("post_rst_cmd_id", bus.cmd_id, 0);
    chk("post_rst_ord_len", bus.ord_len, 0);
    for (int i = 0; i < 6; i++) cycle(1'b0, 4'b1000, rand_lens(), 1'b1, 1'b1, 1'b0, '0);

    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 299) == 0);
      cid = ID_W'($urandom_range(0, N_REQ - 1));
      if (m_cnt[cid] == 0 && $urandom_range(0, 9) != 0)
        for (int k = 0; k < N_REQ; k++) if (m_cnt[k] > 0) cid = ID_W'(k);
      cycle(r, N_REQ'($urandom()), rand_lens(), ($urandom_range(0, 9) < 6),
            ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 3), cid);
    end

    idle(4);
    chk("cmd_q_drained", cmd_q.size(), 0);
    chk("ord_q_drained", ord_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
